// File: rtl/ram_clear_seq_if.sv
// ram_clear_seq_if -- RAM write-port bundle between the clear sequencer and
// the RAM it fills.
//
//   wr_en     master -> slave  write strobe
//   wr_bank   master -> slave  bank being written
//   wr_addr   master -> slave  write address within the bank
//   wr_data   master -> slave  write data
//   wr_ready  slave  -> master RAM accepts the write this cycle
//
// A write is transferred on a clock edge where wr_en and wr_ready are both high.
interface ram_clear_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BANK_W = 1
);
  logic              wr_en;
  logic              wr_ready;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/ram_clear_seq.sv
// ram_clear_seq -- power-up / restart sequencer for machine RAM.
//
// Holds the machine core in reset, writes every location of NUM_BANKS banks
// (2^ADDR_W words each) with a selectable pattern, then keeps reset asserted
// for HOLD_CYCLES more cycles before releasing it and pulsing done.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset (starts a mode-0 clear)
//   req        in   synchronous restart request, level sensitive
//   mode       in   fill mode, latched when leaving WAIT:
//                     0 constant FILL, 1 address, 2 FILL/~FILL per block,
//                     3 pseudo-random (macro) or skip (no macro)
//   wr_if      --   RAM write port (master modport of ram_clear_seq_if)
//   sys_reset  out  active-high reset to the machine core
//   busy       out  high while clearing or holding
//   done       out  one-cycle pulse on entry to IDLE
//
// Optional feature macro: RAMCLR_LFSR_EN
//   defined   -> mode 3 fills with a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                seed 16'hACE1), advanced only on accepted writes
//   undefined -> mode 3 performs no writes and goes straight to HOLD
module ram_clear_seq #(
  parameter int               ADDR_W      = 16,
  parameter int               DATA_W      = 8,
  parameter int               NUM_BANKS   = 1,
  parameter logic [DATA_W-1:0] FILL       = {DATA_W{1'b1}},
  parameter int               BLOCK_LOG2  = 6,
  parameter int               HOLD_CYCLES = 16
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            req,
  input  logic [1:0]      mode,
  ram_clear_seq_if.master wr_if,
  output logic            sys_reset,
  output logic            busy,
  output logic            done
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // HOLD_CYCLES of 0 and 1 both give a single HOLD cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2,
    ST_IDLE  = 2'd3
  } state_t;

  state_t            state_q,     state_d;
  logic [BANK_W-1:0] bank_q,      bank_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [HOLD_W-1:0] hold_q,      hold_d;
  logic [1:0]        mode_q,      mode_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              wr_en_q,     wr_en_d;
  logic              sys_reset_q, sys_reset_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              accept;

`ifdef RAMCLR_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Fibonacci form: taps 16,14,13,11 are bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
`endif

  // Data for the word at address a under fill mode m.
  function automatic logic [DATA_W-1:0] fill_data(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a
`ifdef RAMCLR_LFSR_EN
    , input logic [15:0]     l
`endif
  );
    // Widened copy so the block-select bit exists even if BLOCK_LOG2 >= ADDR_W.
    logic [ADDR_W+BLOCK_LOG2:0] a_ext;
    a_ext     = {{(BLOCK_LOG2+1){1'b0}}, a};
    fill_data = FILL;
    case (m)
      2'd1:    fill_data = DATA_W'(a);
      2'd2:    fill_data = a_ext[BLOCK_LOG2] ? ~FILL : FILL;
`ifdef RAMCLR_LFSR_EN
      2'd3:    fill_data = DATA_W'(l);
`endif
      default: fill_data = FILL;
    endcase
  endfunction

  assign accept = wr_en_q & wr_if.wr_ready;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
`ifdef RAMCLR_LFSR_EN
    lfsr_d  = lfsr_q;
`endif

    if (req) begin
      // Restart request wins in every state and aborts any clear in progress.
      state_d = ST_WAIT;
      bank_d  = '0;
      addr_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          mode_d = mode;
`ifdef RAMCLR_LFSR_EN
          state_d = ST_CLEAR;
`else
          state_d = (mode == 2'd3) ? ST_HOLD : ST_CLEAR;
`endif
        end
        ST_CLEAR: begin
          if (accept) begin
            addr_d = addr_q + 1'b1;
`ifdef RAMCLR_LFSR_EN
            lfsr_d = lfsr_step(lfsr_q);
`endif
            if (addr_q == {ADDR_W{1'b1}}) begin
              if (bank_q == LAST_BANK) begin
                state_d = ST_HOLD;
                bank_d  = '0;
                hold_d  = '0;
              end else begin
                bank_d = bank_q + 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: ; // ST_IDLE: wait for req
      endcase
    end

`ifdef RAMCLR_LFSR_EN
    if (state_d == ST_CLEAR && state_q != ST_CLEAR) lfsr_d = LFSR_SEED;
`endif

    // Outputs are registered from the next state so they change on the same
    // edge as the state; sys_reset falls exactly when done rises.
    wr_en_d     = (state_d == ST_CLEAR);
    sys_reset_d = (state_d != ST_IDLE);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_HOLD);
    done_d      = (state_d == ST_IDLE) && (state_q != ST_IDLE);
`ifdef RAMCLR_LFSR_EN
    data_d      = fill_data(mode_d, addr_d, lfsr_d);
`else
    data_d      = fill_data(mode_d, addr_d);
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      bank_q      <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      mode_q      <= 2'd0;
      data_q      <= FILL;
      wr_en_q     <= 1'b0;
      sys_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      sys_reset_q <= sys_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RAMCLR_LFSR_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end
`endif

  assign wr_if.wr_en   = wr_en_q;
  assign wr_if.wr_bank = bank_q;
  assign wr_if.wr_addr = addr_q;
  assign wr_if.wr_data = data_q;
  assign sys_reset     = sys_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ram_clear_seq.sv
// tb_ram_clear_seq -- directed bench for ram_clear_seq.
// DUT build: ADDR_W=3 (8 words/bank), NUM_BANKS=3, DATA_W=8, FILL=8'hA5,
// BLOCK_LOG2=1, HOLD_CYCLES=3.  A full clear is 24 accepted writes.
module tb_ram_clear_seq;

  localparam int DEPTH = 8;
  localparam int NB    = 3;
  localparam int TOTAL = DEPTH * NB;
  localparam int HOLD  = 3;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       req;
  logic [1:0] mode;
  logic       sys_reset, busy, done;
  logic [3:0] rdy_pat;
  int         pidx = 0;
  int         checks = 0;
  int         failures = 0;

  ram_clear_seq_if #(.ADDR_W(3), .DATA_W(8), .BANK_W(2)) wr_if ();

  ram_clear_seq #(
    .ADDR_W(3), .DATA_W(8), .NUM_BANKS(NB), .FILL(8'hA5),
    .BLOCK_LOG2(1), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(req), .mode(mode),
    .wr_if(wr_if), .sys_reset(sys_reset), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // wr_ready follows a 4-cycle pattern, read left to right.
  initial begin
    wr_if.wr_ready = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      wr_if.wr_ready = rdy_pat[3 - pidx];
      pidx = (pidx + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_nth(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l[7:0];
  endfunction

  function automatic logic [7:0] exp_data(input logic [1:0] m, input logic [2:0] a, input int n);
    case (m)
      2'd1:    return {5'b0, a};
      2'd2:    return a[1] ? 8'h5A : 8'hA5;
      2'd3:    return lfsr_nth(n);
      default: return 8'hA5;
    endcase
  endfunction

  // Watch one clear from its first cycle (cycle 0) to a few cycles into IDLE.
  task automatic observe(input logic [1:0] m, input logic [1:0] m_after, input int exp_n,
                         input logic [7:0] exp_f, input logic [7:0] exp_d2, input string nm);
    int n = 0, errs = 0, stall_errs = 0, dones = 0, cyc = 0, last = 0, fall = -1;
    logic pend = 1'b0, done_at_fall = 1'b0, fin = 1'b0;
    logic [12:0] prev = '0;
    logic [7:0] first = '0, d2 = '0;
    while (!fin && cyc < 400) begin
      @(negedge clk_sys);
      if (cyc == 1) mode = m_after;  // ignored: already past WAIT
      if (pend && wr_if.wr_en && {wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data} != prev)
        stall_errs++;
      pend = wr_if.wr_en && !wr_if.wr_ready;
      prev = {wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data};
      if (wr_if.wr_en && wr_if.wr_ready) begin
        if (wr_if.wr_bank != 2'(n / DEPTH) || wr_if.wr_addr != 3'(n % DEPTH) ||
            wr_if.wr_data != exp_data(m, 3'(n % DEPTH), n) || !sys_reset)
          errs++;
        if (n == 0) first = wr_if.wr_data;
        if (n == 2) d2 = wr_if.wr_data;
        n++;
        last = cyc;
      end
      if (done) dones++;
      if (fall < 0 && !sys_reset) begin
        fall = cyc;
        done_at_fall = done;
      end
      if (fall >= 0 && cyc >= fall + 3) fin = 1'b1;
      cyc++;
    end
    chk({nm, " completed"}, 32'(fall >= 0), 32'd1);
    chk({nm, " write_count"}, n, exp_n);
    chk({nm, " write_seq_errs"}, errs, 0);
    chk({nm, " stall_hold_errs"}, stall_errs, 0);
    chk({nm, " done_pulses"}, dones, 1);
    chk({nm, " done_at_reset_fall"}, 32'(done_at_fall), 32'd1);
    chk({nm, " hold_gap"}, fall - last, HOLD + 1);
    if (exp_n > 2) begin
      chk({nm, " first_data"}, first, exp_f);
      chk({nm, " third_data"}, d2, exp_d2);
    end
    chk({nm, " idle_outputs"}, {wr_if.wr_en, busy, sys_reset, done}, 4'b0000);
  endtask

  task automatic pulse_req(input logic [1:0] m, input logic [3:0] pat);
    @(posedge clk_sys);
    #1;
    mode = m;
    rdy_pat = pat;
    req = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    req = 1'b0;
  endtask

  typedef struct {
    logic [1:0] m;
    logic [1:0] m_after;
    logic [3:0] pat;
    int         exp_n;
    logic [7:0] f;
    logic [7:0] d2;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int  wd;
    logic found;
    int  bad_en, bad_rst, bad_done;

    vecs[0] = '{m: 2'd1, m_after: 2'd2, pat: 4'b1111, exp_n: TOTAL, f: 8'h00, d2: 8'h02};
    vecs[1] = '{m: 2'd2, m_after: 2'd0, pat: 4'b1001, exp_n: TOTAL, f: 8'hA5, d2: 8'h5A};
    vecs[2] = '{m: 2'd0, m_after: 2'd3, pat: 4'b1011, exp_n: TOTAL, f: 8'hA5, d2: 8'hA5};
`ifdef RAMCLR_LFSR_EN
    vecs[3] = '{m: 2'd3, m_after: 2'd1, pat: 4'b1111, exp_n: TOTAL, f: 8'hE1, d2: 8'h38};
`else
    vecs[3] = '{m: 2'd3, m_after: 2'd1, pat: 4'b1111, exp_n: 0, f: 8'h00, d2: 8'h00};
`endif

    reset_n = 1'b0;
    req     = 1'b0;
    mode    = 2'd0;
    rdy_pat = 4'b1111;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset sys_reset", sys_reset, 1);
    chk("reset wr_en", wr_if.wr_en, 0);
    chk("reset busy", busy, 1);
    chk("reset done", done, 0);
    chk("reset bank_addr", {wr_if.wr_bank, wr_if.wr_addr}, 0);

    // Power-up clear: mode 0 straight out of reset.
    reset_n = 1'b1;
    observe(2'd0, 2'd0, TOTAL, 8'hA5, 8'hA5, "pwrup");

    for (int i = 0; i < 4; i++) begin
      pulse_req(vecs[i].m, vecs[i].pat);
      observe(vecs[i].m, vecs[i].m_after, vecs[i].exp_n, vecs[i].f, vecs[i].d2,
              $sformatf("vec%0d", i));
    end

    // Abort a mode-1 clear at bank 0 address 7, hold req for 5 cycles.
    pulse_req(2'd1, 4'b1111);
    found = 1'b0;
    wd = 0;
    while (!found && wd < 100) begin
      @(negedge clk_sys);
      if (wr_if.wr_en && wr_if.wr_bank == 2'd0 && wr_if.wr_addr == 3'd7) found = 1'b1;
      wd++;
    end
    chk("abort reached_addr7", found, 1);
    @(posedge clk_sys);
    #1;
    req = 1'b1;
    bad_en = 0; bad_rst = 0; bad_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (i > 0 && wr_if.wr_en) bad_en++;
      if (!sys_reset) bad_rst++;
      if (done) bad_done++;
    end
    chk("abort wr_en_during_req", bad_en, 0);
    chk("abort sys_reset_during_req", bad_rst, 0);
    chk("abort done_during_req", bad_done, 0);
    @(posedge clk_sys);
    #1;
    req = 1'b0;
    observe(2'd1, 2'd1, TOTAL, 8'h00, 8'h02, "abort");

    // Async reset while in HOLD of a mode-2 clear.
    pulse_req(2'd2, 4'b1111);
    found = 1'b0;
    wd = 0;
    while (!found && wd < 200) begin
      @(negedge clk_sys);
      if (busy && !wr_if.wr_en && sys_reset) found = 1'b1;
      wd++;
    end
    chk("hold reached", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("hold_rst outputs", {sys_reset, wr_if.wr_en, busy, done}, 4'b1010);
    chk("hold_rst addr", {wr_if.wr_bank, wr_if.wr_addr}, 0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    observe(2'd0, 2'd2, TOTAL, 8'hA5, 8'hA5, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
